mips_inst_encoder: RTL and testbench
====================================

// Module: mips_inst_encoder
// PURPOSE
//  Inverse of the instruction decoder: takes one decoded-operation request (alu_ctl, regs, immediate)
//  per valid/ready handshake and emits 32-bit MIPS words on an instruction stream with a running PC.
//  Immediates that do not fit 16 bits are expanded to lui/ori/$at sequences. Feeds test-program
//  generation and decode round-trip checking; the output stream is decoder-compatible (valid + data + pc).
// PARAMETERS
//  BASE_PC  32'h0040_0000  PC of the first emitted word after reset; ADDR_WIDTH-bit.
// PORTS
//  clk              in   1            clock; sole clock domain
//  rst_n            in   1            reset; asynchronous assert, active-low
//  in_valid         in   1            request valid
//  in_ready         out  1            request accepted on in_valid & in_ready
//  in_alu_ctl       in   AluCtl       operation (mips_core_pkg::AluCtl)
//  in_is_mem_access in   1            1: LW/SW (in_alu_ctl must be ALUCTL_ADD)
//  in_mem_action    in   MemAccessType READ=lw, WRITE=sw
//  in_is_jump       in   1            1: J (in_alu_ctl ignored)
//  in_rs/in_rt/in_rw in  MipsReg      source/source/dest registers (5 b each)
//  in_uses_immediate in  1            1: I-type form using in_immediate
//  in_immediate     in   32           imm / shamt[4:0] / branch word offset / J byte target
//  out_valid        out  1            out_data/out_pc valid; held until out_ready
//  out_ready        in   1            consumer takes word on out_valid & out_ready
//  out_data         out  32           encoded instruction
//  out_pc           out  ADDR_WIDTH   PC of out_data
//  out_err          out  1            1-cycle pulse: accepted request was unencodable and dropped
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_pc=BASE_PC, out_err=0, state=IDLE, next_pc=BASE_PC.
//  Output slot: single register. load = slot empty or (out_valid & out_ready). Loading sets out_pc=next_pc,
//   next_pc+=4 (wraps mod 2^ADDR_WIDTH). out_data/out_pc stable while out_valid & !out_ready.
//  in_ready = (state==IDLE) & load. Latency: accept at cycle N -> out_valid at N+1.
//  Encoding (rs/rt/rd at [25:21]/[20:16]/[15:11]):
//   R-type ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLLV/SRLV/SRAV: funct 20/21/22/23/24/25/26/27/2a/2b/04/06/07.
//   SLL/SRL/SRA: funct 00/02/03, in_rs -> rt field, rs field 0, shamt=imm[4:0].
//   Imm ADD/ADDU/SLT/SLTU -> op 08/09/0a/0b, fits iff imm[31:15] all equal.
//   Imm AND/OR/XOR -> op 0c/0d/0e, fits iff imm[31:16]==0. rt field = in_rw.
//   LW/SW: op 23/2b, rt=in_rw (lw) / in_rt (sw); offset must fit signed 16 else error.
//   BEQ/BNE: op 04/05, imm field = in_immediate[15:0]; must fit signed 16 else error.
//   J: op 02, [25:0]=in_immediate[27:2]; error if in_immediate[1:0]!=0.
//  Expansion (imm ALU op not fitting, or imm SUB/SUBU/NOR/SLLV/SRLV/SRAV): FSM
//   IDLE -accept-> LUI: emit lui $at,imm[31:16] -> ORI: emit ori $at,$at,imm[15:0]
//   -> OP: emit R-type rd=in_rw, rs=in_rs, rt=$at -> IDLE. Each step advances only on load.
//   Request fields captured at accept; inputs ignored until IDLE. PCs consecutive (+0,+4,+8).
//  Errors (out_err pulse at N+1, nothing emitted, next_pc unchanged): unsupported alu_ctl, non-fitting
//   mem/branch offset, misaligned J, expansion with in_rs==$at or in_rw==$at.
//  Simultaneous out_ready and accept: old word leaves, new word loads same edge (full throughput).
//  Reset mid-expansion: abort immediately; partial sequence never completes.
// STRUCTURE
//  mips_core_pkg: opcode/funct localparams, fits_s16/fits_u16 functions. Local enum EncState
//   {IDLE,LUI,ORI,OP}. One sub-module: mips_inst_formatter (combinational field packer + fit check).
// TESTING
//  ADDU rs=2 rw=3 imm=5 -> one word 32'h2443_0005 at pc 32'h0040_0000; out_err=0.
//  OR rs=4 rw=5 imm=32'h1234_5678 -> 3C01_1234, 3421_5678, 0081_2825 at pcs +0,+4,+8; in_ready=0 during.
//  BEQ rs=1 rt=2 imm=-1 -> 32'h1022_FFFF; J imm=32'h0040_0000 -> 32'h0810_0000.
//  SW imm=32'h0000_8000 -> out_err pulse 1 cycle, no out_valid, next word keeps old next_pc.
//  Hold out_ready=0 3 cycles with word pending -> out_data/out_pc stable, in_ready=0; release -> 1 word/cycle.
//  Assert rst_n=0 after LUI emitted -> out_valid=0, out_pc=BASE_PC, next request encodes from IDLE.

Source files
------------

// File: rtl/mips_inst_encoder_pkg.sv
// Shared MIPS definitions for the instruction encoder: operation/register types,
// opcode and funct constants, immediate fit checks and instruction-word packers.
package mips_core_pkg;

  typedef enum logic [4:0] {
    ALUCTL_ADD   = 5'd0,
    ALUCTL_ADDU  = 5'd1,
    ALUCTL_SUB   = 5'd2,
    ALUCTL_SUBU  = 5'd3,
    ALUCTL_AND   = 5'd4,
    ALUCTL_OR    = 5'd5,
    ALUCTL_XOR   = 5'd6,
    ALUCTL_NOR   = 5'd7,
    ALUCTL_SLT   = 5'd8,
    ALUCTL_SLTU  = 5'd9,
    ALUCTL_SLL   = 5'd10,
    ALUCTL_SRL   = 5'd11,
    ALUCTL_SRA   = 5'd12,
    ALUCTL_SLLV  = 5'd13,
    ALUCTL_SRLV  = 5'd14,
    ALUCTL_SRAV  = 5'd15,
    ALUCTL_LUI   = 5'd16,
    ALUCTL_MULT  = 5'd17,
    ALUCTL_MULTU = 5'd18,
    ALUCTL_DIV   = 5'd19,
    ALUCTL_DIVU  = 5'd20,
    ALUCTL_BEQ   = 5'd21,
    ALUCTL_BNE   = 5'd22,
    ALUCTL_NOP   = 5'd23
  } AluCtl;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } MemAccessType;

  typedef logic [4:0] MipsReg;

  localparam MipsReg REG_ZERO = 5'd0;
  localparam MipsReg REG_AT   = 5'd1;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // Value survives sign-extension from 16 bits: upper 17 bits all equal.
  function automatic logic fits_s16(input logic [31:0] v);
    return (&v[31:15]) | ~(|v[31:15]);
  endfunction

  function automatic logic fits_u16(input logic [31:0] v);
    return ~(|v[31:16]);
  endfunction

  function automatic logic [31:0] r_word(input MipsReg rs, input MipsReg rt, input MipsReg rd,
                                         input logic [4:0] shamt, input logic [5:0] funct);
    return {OP_SPECIAL, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input MipsReg rs, input MipsReg rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/mips_inst_encoder_formatter.sv
// Combinational packer: classifies one request as a single word, a lui/ori/$at
// expansion, or unencodable, and builds the words involved.
module mips_inst_formatter
  import mips_core_pkg::*;
(
  input  AluCtl        alu_ctl,
  input  logic         is_mem_access,
  input  MemAccessType mem_action,
  input  logic         is_jump,
  input  MipsReg       rs,
  input  MipsReg       rt,
  input  MipsReg       rw,
  input  logic         uses_immediate,
  input  logic [31:0]  immediate,
  output logic [31:0]  word,
  output logic         expand,
  output logic         err,
  output logic [31:0]  op_word
);

  logic [5:0] funct_s;
  logic       has_funct_s;
  logic [5:0] imm_op_s;
  logic       has_imm_op_s;
  logic       imm_signed_s;
  logic       imm_fits_s;
  logic       is_shift_s;
  logic       is_branch_s;

  // R-type funct for every operation that has a register form
  always_comb begin
    funct_s     = 6'h00;
    has_funct_s = 1'b1;
    case (alu_ctl)
      ALUCTL_ADD:  funct_s = FN_ADD;
      ALUCTL_ADDU: funct_s = FN_ADDU;
      ALUCTL_SUB:  funct_s = FN_SUB;
      ALUCTL_SUBU: funct_s = FN_SUBU;
      ALUCTL_AND:  funct_s = FN_AND;
      ALUCTL_OR:   funct_s = FN_OR;
      ALUCTL_XOR:  funct_s = FN_XOR;
      ALUCTL_NOR:  funct_s = FN_NOR;
      ALUCTL_SLT:  funct_s = FN_SLT;
      ALUCTL_SLTU: funct_s = FN_SLTU;
      ALUCTL_SLL:  funct_s = FN_SLL;
      ALUCTL_SRL:  funct_s = FN_SRL;
      ALUCTL_SRA:  funct_s = FN_SRA;
      ALUCTL_SLLV: funct_s = FN_SLLV;
      ALUCTL_SRLV: funct_s = FN_SRLV;
      ALUCTL_SRAV: funct_s = FN_SRAV;
      default:     has_funct_s = 1'b0;
    endcase
  end

  // I-type opcode; arithmetic forms sign-extend, logical forms zero-extend
  always_comb begin
    imm_op_s     = 6'h00;
    has_imm_op_s = 1'b1;
    imm_signed_s = 1'b1;
    case (alu_ctl)
      ALUCTL_ADD:  imm_op_s = OP_ADDI;
      ALUCTL_ADDU: imm_op_s = OP_ADDIU;
      ALUCTL_SLT:  imm_op_s = OP_SLTI;
      ALUCTL_SLTU: imm_op_s = OP_SLTIU;
      ALUCTL_AND:  begin imm_op_s = OP_ANDI; imm_signed_s = 1'b0; end
      ALUCTL_OR:   begin imm_op_s = OP_ORI;  imm_signed_s = 1'b0; end
      ALUCTL_XOR:  begin imm_op_s = OP_XORI; imm_signed_s = 1'b0; end
      default:     has_imm_op_s = 1'b0;
    endcase
  end

  assign imm_fits_s  = imm_signed_s ? fits_s16(immediate) : fits_u16(immediate);
  assign is_shift_s  = (alu_ctl == ALUCTL_SLL) | (alu_ctl == ALUCTL_SRL) | (alu_ctl == ALUCTL_SRA);
  assign is_branch_s = (alu_ctl == ALUCTL_BEQ) | (alu_ctl == ALUCTL_BNE);

  // Format selection; jump and memory flags take precedence over alu_ctl
  always_comb begin
    word    = 32'h0000_0000;
    expand  = 1'b0;
    err     = 1'b0;
    op_word = r_word(rs, REG_AT, rw, 5'd0, funct_s);
    if (is_jump) begin
      if (immediate[1:0] != 2'b00) err = 1'b1;
      else                         word = j_word(OP_J, immediate[27:2]);
    end else if (is_mem_access) begin
      if ((alu_ctl != ALUCTL_ADD) || !fits_s16(immediate)) err = 1'b1;
      else if (mem_action == MEM_READ) word = i_word(OP_LW, rs, rw, immediate[15:0]);
      else                             word = i_word(OP_SW, rs, rt, immediate[15:0]);
    end else if (is_branch_s) begin
      if (!fits_s16(immediate)) err = 1'b1;
      else word = i_word((alu_ctl == ALUCTL_BEQ) ? OP_BEQ : OP_BNE, rs, rt, immediate[15:0]);
    end else if (is_shift_s) begin
      word = r_word(REG_ZERO, rs, rw, immediate[4:0], funct_s);
    end else if (!has_funct_s) begin
      err = 1'b1;
    end else if (!uses_immediate) begin
      word = r_word(rs, rt, rw, 5'd0, funct_s);
    end else if (has_imm_op_s && imm_fits_s) begin
      word = i_word(imm_op_s, rs, rw, immediate[15:0]);
    end else if ((rs == REG_AT) || (rw == REG_AT)) begin
      // the expansion clobbers $at, so it cannot also be an operand
      err = 1'b1;
    end else begin
      expand = 1'b1;
    end
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// Decoded-operation to MIPS word encoder with a one-entry output slot, a running PC
// and a lui/ori/$at expansion sequencer for immediates without a 16-bit form.
module mips_inst_encoder
  import mips_core_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_PC    = ADDR_WIDTH'(32'h0040_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  AluCtl                 in_alu_ctl,
  input  logic                  in_is_mem_access,
  input  MemAccessType          in_mem_action,
  input  logic                  in_is_jump,
  input  MipsReg                in_rs,
  input  MipsReg                in_rt,
  input  MipsReg                in_rw,
  input  logic                  in_uses_immediate,
  input  logic [31:0]           in_immediate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LUI  = 2'd1,
    ORI  = 2'd2,
    OP   = 2'd3
  } EncState;

  EncState               state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                  out_err_q, out_err_d;
  logic [31:0]           imm_q, imm_d;
  logic [31:0]           op_word_q, op_word_d;

  logic        load_s;
  logic        accept_s;
  logic        emit_s;
  logic [31:0] emit_word_s;
  logic [31:0] fmt_word_s;
  logic        fmt_expand_s;
  logic        fmt_err_s;
  logic [31:0] fmt_op_word_s;

  mips_inst_formatter u_formatter (
    .alu_ctl        (in_alu_ctl),
    .is_mem_access  (in_is_mem_access),
    .mem_action     (in_mem_action),
    .is_jump        (in_is_jump),
    .rs             (in_rs),
    .rt             (in_rt),
    .rw             (in_rw),
    .uses_immediate (in_uses_immediate),
    .immediate      (in_immediate),
    .word           (fmt_word_s),
    .expand         (fmt_expand_s),
    .err            (fmt_err_s),
    .op_word        (fmt_op_word_s)
  );

  assign load_s   = ~out_valid_q | out_ready;
  assign in_ready = (state_q == IDLE) & load_s;
  assign accept_s = in_valid & in_ready;

  // Sequencer: state names the next expansion word still owed to the slot
  always_comb begin
    state_d     = state_q;
    imm_d       = imm_q;
    op_word_d   = op_word_q;
    out_err_d   = 1'b0;
    emit_s      = 1'b0;
    emit_word_s = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          emit_s = 1'b0;
        end else if (fmt_err_s) begin
          out_err_d = 1'b1;
        end else if (fmt_expand_s) begin
          emit_s      = 1'b1;
          emit_word_s = i_word(OP_LUI, REG_ZERO, REG_AT, in_immediate[31:16]);
          imm_d       = in_immediate;
          op_word_d   = fmt_op_word_s;
          state_d     = ORI;
        end else begin
          emit_s      = 1'b1;
          emit_word_s = fmt_word_s;
        end
      end
      LUI: begin
        if (load_s) begin
          emit_s      = 1'b1;
          emit_word_s = i_word(OP_LUI, REG_ZERO, REG_AT, imm_q[31:16]);
          state_d     = ORI;
        end else begin
          emit_s = 1'b0;
        end
      end
      ORI: begin
        if (load_s) begin
          emit_s      = 1'b1;
          emit_word_s = i_word(OP_ORI, REG_AT, REG_AT, imm_q[15:0]);
          state_d     = OP;
        end else begin
          emit_s = 1'b0;
        end
      end
      OP: begin
        if (load_s) begin
          emit_s      = 1'b1;
          emit_word_s = op_word_q;
          state_d     = IDLE;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: emitting always coincides with load, so a departing word is replaced same edge
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    next_pc_d   = next_pc_q;
    if (emit_s) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_word_s;
      out_pc_d    = next_pc_q;
      next_pc_d   = next_pc_q + ADDR_WIDTH'(32'd4);
    end else if (load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset aborts any partially emitted expansion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      next_pc_q   <= BASE_PC;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_pc_q    <= BASE_PC;
      out_err_q   <= 1'b0;
      imm_q       <= 32'h0000_0000;
      op_word_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      next_pc_q   <= next_pc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
      out_err_q   <= out_err_d;
      imm_q       <= imm_d;
      op_word_q   <= op_word_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pc    = out_pc_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Self-checking bench: directed vectors plus randomized requests and backpressure,
// scored against an arithmetic reference encoder and an expected-word queue.
module tb_mips_inst_encoder;
  import mips_core_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  AluCtl        in_alu_ctl = ALUCTL_ADD;
  logic         in_is_mem_access = 1'b0;
  MemAccessType in_mem_action = MEM_READ;
  logic         in_is_jump = 1'b0;
  MipsReg       in_rs = 5'd0, in_rt = 5'd0, in_rw = 5'd0;
  logic         in_uses_immediate = 1'b0;
  logic [31:0]  in_immediate = 32'h0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [31:0]  out_pc;
  logic         out_err;

  mips_inst_encoder #(.ADDR_WIDTH(32), .BASE_PC(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctl(in_alu_ctl), .in_is_mem_access(in_is_mem_access), .in_mem_action(in_mem_action),
    .in_is_jump(in_is_jump), .in_rs(in_rs), .in_rt(in_rt), .in_rw(in_rw),
    .in_uses_immediate(in_uses_immediate), .in_immediate(in_immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    AluCtl       alu;
    bit          mem;
    bit          wr;
    bit          jmp;
    int          rs, rt, rw;
    bit          ui;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc = BASE;
  bit          err_exp = 1'b0;
  bit          rnd_mode = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int lo);
    longint v;
    v = longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(lo);
    return v[31:0];
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    longint v;
    v = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(sh) * 64 + longint'(fn);
    return v[31:0];
  endfunction

  function automatic int funct_of(input AluCtl a);
    case (a)
      ALUCTL_ADD: return 32; ALUCTL_ADDU: return 33; ALUCTL_SUB: return 34; ALUCTL_SUBU: return 35;
      ALUCTL_AND: return 36; ALUCTL_OR: return 37;   ALUCTL_XOR: return 38; ALUCTL_NOR: return 39;
      ALUCTL_SLT: return 42; ALUCTL_SLTU: return 43; ALUCTL_SLL: return 0;  ALUCTL_SRL: return 2;
      ALUCTL_SRA: return 3;  ALUCTL_SLLV: return 4;  ALUCTL_SRLV: return 6; ALUCTL_SRAV: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int imm_op_of(input AluCtl a);
    case (a)
      ALUCTL_ADD: return 8;  ALUCTL_ADDU: return 9;  ALUCTL_SLT: return 10; ALUCTL_SLTU: return 11;
      ALUCTL_AND: return 12; ALUCTL_OR: return 13;   ALUCTL_XOR: return 14;
      default: return -1;
    endcase
  endfunction

  // Reference encoder: the words a request must produce, or an error
  function automatic void model_words(input req_t r, output logic [31:0] w0, output logic [31:0] w1,
                                      output logic [31:0] w2, output int n, output bit err);
    int  off;
    int  fn;
    int  iop;
    bit  s16, u16, fits;
    off = $signed(r.imm);
    s16 = (off >= -32768) && (off <= 32767);
    u16 = (r.imm < 32'h0001_0000);
    fn  = funct_of(r.alu);
    iop = imm_op_of(r.alu);
    fits = (r.alu inside {ALUCTL_ADD, ALUCTL_ADDU, ALUCTL_SLT, ALUCTL_SLTU}) ? s16 : u16;
    w0 = 32'h0; w1 = 32'h0; w2 = 32'h0; n = 0; err = 1'b0;
    if (r.jmp) begin
      if (r.imm % 4 != 0) err = 1'b1;
      else begin n = 1; w0 = 32'h0800_0000 + ((r.imm % 32'h1000_0000) / 4); end
    end else if (r.mem) begin
      if (r.alu != ALUCTL_ADD || !s16) err = 1'b1;
      else begin n = 1; w0 = itype(r.wr ? 43 : 35, r.rs, r.wr ? r.rt : r.rw, int'(r.imm % 65536)); end
    end else if (r.alu == ALUCTL_BEQ || r.alu == ALUCTL_BNE) begin
      if (!s16) err = 1'b1;
      else begin n = 1; w0 = itype(r.alu == ALUCTL_BEQ ? 4 : 5, r.rs, r.rt, int'(r.imm % 65536)); end
    end else if (r.alu inside {ALUCTL_SLL, ALUCTL_SRL, ALUCTL_SRA}) begin
      n = 1; w0 = rtype(0, r.rs, r.rw, int'(r.imm % 32), fn);
    end else if (fn < 0) begin
      err = 1'b1;
    end else if (!r.ui) begin
      n = 1; w0 = rtype(r.rs, r.rt, r.rw, 0, fn);
    end else if (iop >= 0 && fits) begin
      n = 1; w0 = itype(iop, r.rs, r.rw, int'(r.imm % 65536));
    end else if (r.rs == 1 || r.rw == 1) begin
      err = 1'b1;
    end else begin
      n = 3;
      w0 = itype(15, 0, 1, int'(r.imm / 65536));
      w1 = itype(13, 1, 1, int'(r.imm % 65536));
      w2 = rtype(r.rs, 1, r.rw, 0, fn);
    end
  endfunction

  function automatic req_t mk(input AluCtl a, input bit mem, input bit wr, input bit jmp,
                              input int rs, input int rt, input int rw, input bit ui, input logic [31:0] imm);
    req_t r;
    r.alu = a; r.mem = mem; r.wr = wr; r.jmp = jmp; r.rs = rs; r.rt = rt; r.rw = rw; r.ui = ui; r.imm = imm;
    return r;
  endfunction

  // Scoreboard: checks every cycle, then advances the model by this cycle's handshakes
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      err_exp  = 1'b0;
      model_pc = BASE;
    end else begin
      req_t        cur;
      logic [31:0] w0, w1, w2;
      int          n;
      bit          e;
      chk("out_err", 32'(out_err), 32'(err_exp));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_pc", out_pc, exp_q[0].pc);
        if (out_ready) void'(exp_q.pop_front());
      end
      err_exp = 1'b0;
      if (in_valid && in_ready) begin
        cur = mk(in_alu_ctl, in_is_mem_access, in_mem_action == MEM_WRITE, in_is_jump,
                 int'(in_rs), int'(in_rt), int'(in_rw), in_uses_immediate, in_immediate);
        model_words(cur, w0, w1, w2, n, e);
        err_exp = e;
        for (int i = 0; i < n; i++) begin
          exp_q.push_back({(i == 0) ? w0 : (i == 1) ? w1 : w2, model_pc});
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input req_t r);
    bit acc;
    in_alu_ctl = r.alu; in_is_mem_access = r.mem; in_mem_action = r.wr ? MEM_WRITE : MEM_READ;
    in_is_jump = r.jmp; in_rs = 5'(r.rs); in_rt = 5'(r.rt); in_rw = 5'(r.rw);
    in_uses_immediate = r.ui; in_immediate = r.imm; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance within 200 cycles");
    end
  endtask

  task automatic pin(input string name, input req_t r, input int n_exp, input bit err_e,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] w0, w1, w2;
    int n;
    bit e;
    model_words(r, w0, w1, w2, n, e);
    chk({name, "_n"}, 32'(n), 32'(n_exp));
    chk({name, "_err"}, 32'(e), 32'(err_e));
    if (n_exp > 0) chk({name, "_w0"}, w0, e0);
    if (n_exp > 2) begin chk({name, "_w1"}, w1, e1); chk({name, "_w2"}, w2, e2); end
  endtask

  function automatic req_t rand_req();
    logic [31:0] edges [8];
    req_t r;
    int   sel;
    edges = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
              32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    r.alu = AluCtl'($urandom_range(0, 23));
    sel   = $urandom_range(0, 9);
    r.jmp = (sel == 0);
    r.mem = (sel == 1 || sel == 2);
    if (r.mem && $urandom_range(0, 4) != 0) r.alu = ALUCTL_ADD;
    r.wr = 1'($urandom_range(0, 1));
    r.rs = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(0, 31);
    r.rt = $urandom_range(0, 31);
    r.rw = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(0, 31);
    r.ui = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: r.imm = 32'($urandom_range(0, 255));
      1: r.imm = edges[$urandom_range(0, 7)];
      2: r.imm = $urandom;
      3: r.imm = 32'(-$urandom_range(1, 40000));
      4: r.imm = $urandom & 32'h0FFF_FFFC;
      default: r.imm = 32'($urandom_range(0, 65535));
    endcase
    return r;
  endfunction

  initial begin
    pin("pin_addu", mk(ALUCTL_ADDU, 0, 0, 0, 2, 0, 3, 1, 32'd5), 1, 0, 32'h2443_0005, 32'h0, 32'h0);
    pin("pin_or_exp", mk(ALUCTL_OR, 0, 0, 0, 4, 0, 5, 1, 32'h1234_5678), 3, 0,
        32'h3C01_1234, 32'h3421_5678, 32'h0081_2825);
    pin("pin_beq", mk(ALUCTL_BEQ, 0, 0, 0, 1, 2, 0, 1, 32'hFFFF_FFFF), 1, 0, 32'h1022_FFFF, 32'h0, 32'h0);
    pin("pin_j", mk(ALUCTL_ADD, 0, 0, 1, 0, 0, 0, 1, 32'h0040_0000), 1, 0, 32'h0810_0000, 32'h0, 32'h0);
    pin("pin_sw_err", mk(ALUCTL_ADD, 1, 1, 0, 0, 0, 0, 1, 32'h0000_8000), 0, 1, 32'h0, 32'h0, 32'h0);

    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_pc", out_pc, BASE);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    tick();

    send(mk(ALUCTL_ADDU, 0, 0, 0, 2, 0, 3, 1, 32'd5));
    chk("addu_data", out_data, 32'h2443_0005);
    chk("addu_pc", out_pc, 32'h0040_0000);
    chk("addu_err", 32'(out_err), 32'd0);

    send(mk(ALUCTL_OR, 0, 0, 0, 4, 0, 5, 1, 32'h1234_5678));
    chk("lui_data", out_data, 32'h3C01_1234);
    chk("lui_pc", out_pc, 32'h0040_0004);
    chk("exp_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("ori_data", out_data, 32'h3421_5678);
    chk("ori_pc", out_pc, 32'h0040_0008);
    tick();
    chk("op_data", out_data, 32'h0081_2825);
    chk("op_pc", out_pc, 32'h0040_000C);

    send(mk(ALUCTL_BEQ, 0, 0, 0, 1, 2, 0, 1, 32'hFFFF_FFFF));
    chk("beq_data", out_data, 32'h1022_FFFF);
    chk("beq_pc", out_pc, 32'h0040_0010);
    send(mk(ALUCTL_ADD, 0, 0, 1, 0, 0, 0, 1, 32'h0040_0000));
    chk("j_data", out_data, 32'h0810_0000);
    chk("j_pc", out_pc, 32'h0040_0014);

    send(mk(ALUCTL_ADD, 1, 1, 0, 3, 4, 0, 1, 32'h0000_8000));
    chk("sw_err_pulse", 32'(out_err), 32'd1);
    chk("sw_err_novalid", 32'(out_valid), 32'd0);
    tick();
    chk("sw_err_1cycle", 32'(out_err), 32'd0);
    send(mk(ALUCTL_MULT, 0, 0, 0, 2, 3, 4, 0, 32'd0));
    chk("mult_err", 32'(out_err), 32'd1);
    send(mk(ALUCTL_OR, 0, 0, 0, 4, 0, 1, 1, 32'h0001_0000));
    chk("at_err", 32'(out_err), 32'd1);
    send(mk(ALUCTL_ADDU, 0, 0, 0, 2, 0, 3, 1, 32'd5));
    chk("after_err_pc", out_pc, 32'h0040_0018);

    tick();
    out_ready = 1'b0;
    send(mk(ALUCTL_OR, 0, 0, 0, 4, 0, 5, 1, 32'h1234_5678));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", out_data, 32'h3C01_1234);
      chk("hold_pc", out_pc, 32'h0040_001C);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("rel_ori_data", out_data, 32'h3421_5678);
    chk("rel_ori_pc", out_pc, 32'h0040_0020);
    tick();
    chk("rel_op_data", out_data, 32'h0081_2825);
    chk("rel_op_pc", out_pc, 32'h0040_0024);
    tick();
    chk("rel_drained", 32'(out_valid), 32'd0);

    send(mk(ALUCTL_OR, 0, 0, 0, 4, 0, 5, 1, 32'h1234_5678));
    chk("pre_rst_lui", out_data, 32'h3C01_1234);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_pc", out_pc, BASE);
    chk("midrst_data", out_data, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(mk(ALUCTL_ADDU, 0, 0, 0, 2, 0, 3, 1, 32'd5));
    chk("postrst_data", out_data, 32'h2443_0005);
    chk("postrst_pc", out_pc, BASE);

    rnd_mode = 1'b1;
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(rand_req());
    end
    rnd_mode = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    tick();
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
